// File: rtl/score_bcd_ctrl.sv
// Saturating score register with a sequencer that drives an external binary-to-BCD
// converter and latches its digits for display. Optional macro: LEAD_ZERO_BLANK_EN.
module score_bcd_ctrl #(
  parameter int MAX_SCORE   = 9999,
  parameter int CONV_CYCLES = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic [3:0]  inc_amt,
  input  logic        clr,
  output logic [13:0] score,
  output logic        conv_start,
  input  logic [3:0]  bcd3,
  input  logic [3:0]  bcd2,
  input  logic [3:0]  bcd1,
  input  logic [3:0]  bcd0,
  output logic [3:0]  disp3,
  output logic [3:0]  disp2,
  output logic [3:0]  disp1,
  output logic [3:0]  disp0,
  output logic        disp_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, LATCH} state_t;

  localparam logic [4:0]  CNT_LAST  = 5'(CONV_CYCLES + 1);
  localparam logic [14:0] SCORE_MAX = 15'(MAX_SCORE);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [13:0] score_q, score_d;
  logic        pending_q, pending_d;
  logic [15:0] disp_q, disp_d;
  logic        disp_valid_q, disp_valid_d;

  // Sum is formed one bit wider than the score so the compare sees the true value.
  function automatic logic [13:0] sat_add(input logic [13:0] s, input logic [3:0] a);
    logic [14:0] sum;
    sum = {1'b0, s} + {11'b0, a};
    if (sum > SCORE_MAX) begin
      return SCORE_MAX[13:0];
    end
    return sum[13:0];
  endfunction

  function automatic logic [15:0] latch_digits(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef LEAD_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && d[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
`else
    r = d;
`endif
    return r;
  endfunction

  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (inc) begin
      score_d = sat_add(score_q, inc_amt);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (pending_q) state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) state_d = LATCH;
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    conv_start = (state_q == START);
    busy       = (state_q != IDLE);
  end

  // A new score change outranks the clear that happens on entry to START.
  always_comb begin
    pending_d = pending_q;
    if (state_q == IDLE && state_d == START) begin
      pending_d = 1'b0;
    end
    if (score_d != score_q) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    if (state_q == LATCH) begin
      disp_d       = latch_digits({bcd3, bcd2, bcd1, bcd0});
      disp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q      <= '0;
      pending_q    <= 1'b1;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      score_q      <= score_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign score      = score_q;
  assign disp3      = disp_q[15:12];
  assign disp2      = disp_q[11:8];
  assign disp1      = disp_q[7:4];
  assign disp0      = disp_q[3:0];
  assign disp_valid = disp_valid_q;

endmodule
